// File: rtl/jump_branch_control_unit.sv
// Hardwired control sequencer for instruction fetch and the control-transfer
// class (jr, jal, br) plus nop/halt. State advances on the falling clock edge,
// so every strobe is settled before the datapath samples on the rising edge.
module jump_branch_control_unit #(
   parameter logic [4:0] OP_BR   = 5'b10011,
   parameter logic [4:0] OP_JR   = 5'b10100,
   parameter logic [4:0] OP_JAL  = 5'b10101,
   parameter logic [4:0] OP_NOP  = 5'b11010,
   parameter logic [4:0] OP_HALT = 5'b11011
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        con,
   input  logic        mem_ready,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        memRead,
   output logic        ramEnable,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Gra,
   output logic        Rout,
   output logic        PCin,
   output logic        R15in,
   output logic        CONin,
   output logic        Yin,
   output logic        Cout,
   output logic        ADD,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        BAout,
   output logic        run,
   output logic        unsupported,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [4:0] w_opcode;
   logic       w_unusedIr;

   assign w_opcode   = ir[31:27];
   assign w_unusedIr = ^ir[26:0];

   // These strobes belong to other instruction classes and stay idle here
   assign Grb   = 1'b0;
   assign Grc   = 1'b0;
   assign Rin   = 1'b0;
   assign BAout = 1'b0;

   assign run   = (r_state != S_HALT);
   assign state = r_state;

   // State register: falling-edge update, clear forces IDLE even mid-instruction
   always_ff @(negedge clock or negedge clear) begin
      if (!clear) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and Moore strobe decode from the current T-state and opcode
   always_comb begin
      w_next      = r_state;
      PCout       = 1'b0;
      MARin       = 1'b0;
      IncPC       = 1'b0;
      memRead     = 1'b0;
      ramEnable   = 1'b0;
      MDRin       = 1'b0;
      MDRout      = 1'b0;
      IRin        = 1'b0;
      Gra         = 1'b0;
      Rout        = 1'b0;
      PCin        = 1'b0;
      R15in       = 1'b0;
      CONin       = 1'b0;
      Yin         = 1'b0;
      Cout        = 1'b0;
      ADD         = 1'b0;
      Zin         = 1'b0;
      Zlowout     = 1'b0;
      unsupported = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_next = S_T0;
         end
         S_T0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            w_next = S_T1;
         end
         S_T1: begin
            memRead   = 1'b1;
            ramEnable = 1'b1;
            MDRin     = 1'b1;
            if (mem_ready) begin
               w_next = S_T2;
            end
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
            w_next = S_T3;
         end
         S_T3: begin
            case (w_opcode)
               OP_JR: begin
                  Gra    = 1'b1;
                  Rout   = 1'b1;
                  PCin   = 1'b1;
                  w_next = S_T0;
               end
               OP_JAL: begin
                  PCout  = 1'b1;
                  R15in  = 1'b1;
                  w_next = S_T4;
               end
               OP_BR: begin
                  Gra    = 1'b1;
                  Rout   = 1'b1;
                  CONin  = 1'b1;
                  w_next = S_T4;
               end
               OP_NOP: begin
                  w_next = S_T0;
               end
               OP_HALT: begin
                  w_next = S_HALT;
               end
               default: begin
                  unsupported = 1'b1;
                  w_next      = S_T0;
               end
            endcase
         end
         S_T4: begin
            if (w_opcode == OP_JAL) begin
               Gra    = 1'b1;
               Rout   = 1'b1;
               PCin   = 1'b1;
               w_next = S_T0;
            end else if (w_opcode == OP_BR) begin
               PCout  = 1'b1;
               Yin    = 1'b1;
               w_next = S_T5;
            end else begin
               w_next = S_T0;
            end
         end
         S_T5: begin
            Cout   = 1'b1;
            ADD    = 1'b1;
            Zin    = 1'b1;
            w_next = S_T6;
         end
         S_T6: begin
            Zlowout = 1'b1;
            PCin    = con;
            w_next  = S_T0;
         end
         S_HALT: begin
            w_next = S_HALT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_jump_branch_control_unit.sv
// Scoreboard bench for jump_branch_control_unit: the stimulus process queues
// the hand-computed state/strobe vector for each cycle and a monitor pops and
// compares on every rising edge, midway between falling-edge state updates.
module tb_jump_branch_control_unit;

   logic        clock;
   logic        clear;
   logic [31:0] ir;
   logic        con;
   logic        memReady;
   logic PCout, MARin, IncPC, memRead, ramEnable, MDRin, MDRout, IRin;
   logic Gra, Rout, PCin, R15in, CONin, Yin, Cout, ADD, Zin, Zlowout;
   logic Grb, Grc, Rin, BAout, run, unsupported;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;

   logic [27:0] expQ[$];
   string       nameQ[$];

   localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3;
   localparam logic [3:0] ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7;
   localparam logic [3:0] ST_HALT = 4'd8;

   localparam logic [23:0] B_RUN   = 24'd1 << 23;
   localparam logic [23:0] B_UNS   = 24'd1 << 22;
   localparam logic [23:0] B_PCOUT = 24'd1 << 21;
   localparam logic [23:0] B_MARIN = 24'd1 << 20;
   localparam logic [23:0] B_INCPC = 24'd1 << 19;
   localparam logic [23:0] B_MREAD = 24'd1 << 18;
   localparam logic [23:0] B_RAMEN = 24'd1 << 17;
   localparam logic [23:0] B_MDRIN = 24'd1 << 16;
   localparam logic [23:0] B_MDROUT = 24'd1 << 15;
   localparam logic [23:0] B_IRIN  = 24'd1 << 14;
   localparam logic [23:0] B_GRA   = 24'd1 << 13;
   localparam logic [23:0] B_ROUT  = 24'd1 << 12;
   localparam logic [23:0] B_PCIN  = 24'd1 << 11;
   localparam logic [23:0] B_R15IN = 24'd1 << 10;
   localparam logic [23:0] B_CONIN = 24'd1 << 9;
   localparam logic [23:0] B_YIN   = 24'd1 << 8;
   localparam logic [23:0] B_COUT  = 24'd1 << 7;
   localparam logic [23:0] B_ADD   = 24'd1 << 6;
   localparam logic [23:0] B_ZIN   = 24'd1 << 5;
   localparam logic [23:0] B_ZLOW  = 24'd1 << 4;

   localparam logic [23:0] O_IDLE = B_RUN;
   localparam logic [23:0] O_T0   = B_RUN | B_PCOUT | B_MARIN | B_INCPC;
   localparam logic [23:0] O_T1   = B_RUN | B_MREAD | B_RAMEN | B_MDRIN;
   localparam logic [23:0] O_T2   = B_RUN | B_MDROUT | B_IRIN;
   localparam logic [23:0] O_JR3  = B_RUN | B_GRA | B_ROUT | B_PCIN;
   localparam logic [23:0] O_JAL3 = B_RUN | B_PCOUT | B_R15IN;
   localparam logic [23:0] O_BR3  = B_RUN | B_GRA | B_ROUT | B_CONIN;
   localparam logic [23:0] O_BR4  = B_RUN | B_PCOUT | B_YIN;
   localparam logic [23:0] O_BR5  = B_RUN | B_COUT | B_ADD | B_ZIN;
   localparam logic [23:0] O_BR6T = B_RUN | B_ZLOW | B_PCIN;
   localparam logic [23:0] O_BR6N = B_RUN | B_ZLOW;
   localparam logic [23:0] O_NONE = B_RUN;
   localparam logic [23:0] O_UNS  = B_RUN | B_UNS;
   localparam logic [23:0] O_HALT = 24'h000000;

   localparam logic [31:0] IR_JR   = 32'hA3000000;
   localparam logic [31:0] IR_BR   = 32'h99800005;
   localparam logic [31:0] IR_JAL  = 32'hA8800000;
   localparam logic [31:0] IR_NOP  = 32'hD0000000;
   localparam logic [31:0] IR_UNS  = 32'h18000000;
   localparam logic [31:0] IR_HALT = 32'hD8000000;

   jump_branch_control_unit dut (
      .clock(clock), .clear(clear), .ir(ir), .con(con), .mem_ready(memReady),
      .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .memRead(memRead),
      .ramEnable(ramEnable), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
      .Gra(Gra), .Rout(Rout), .PCin(PCin), .R15in(R15in), .CONin(CONin),
      .Yin(Yin), .Cout(Cout), .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout),
      .Grb(Grb), .Grc(Grc), .Rin(Rin), .BAout(BAout), .run(run),
      .unsupported(unsupported), .state(state)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Compare one queued expectation against the live DUT outputs
   task automatic checkOutput(input string name, input logic [27:0] expVec);
      logic [27:0] actVec;
      actVec = {state, run, unsupported, PCout, MARin, IncPC, memRead, ramEnable,
                MDRin, MDRout, IRin, Gra, Rout, PCin, R15in, CONin, Yin, Cout,
                ADD, Zin, Zlowout, Grb, Grc, Rin, BAout};
      checks++;
      if (actVec !== expVec) begin
         errors++;
         $display("[TB] FAIL %s: got state=%0d strobes=%h, expected state=%0d strobes=%h",
                  name, actVec[27:24], actVec[23:0], expVec[27:24], expVec[23:0]);
      end
   endtask

   // Monitor: every rising edge is a sample point for the state entered at the last falling edge
   always @(posedge clock) begin
      if (expQ.size() > 0) begin
         checkOutput(nameQ.pop_front(), expQ.pop_front());
      end
   end

   // Drive one cycle of inputs, queue the expected outputs, advance past the next falling edge
   task automatic applyStimulus(input string name, input logic clr, input logic [31:0] irv,
                                input logic conv, input logic rdy,
                                input logic [3:0] expState, input logic [23:0] expOut);
      clear    = clr;
      ir       = irv;
      con      = conv;
      memReady = rdy;
      expQ.push_back({expState, expOut});
      nameQ.push_back(name);
      @(negedge clock);
      #1;
   endtask

   // Fetch sequence T0/T1/T2 with an optional number of memory wait cycles in T1
   task automatic fetchInstr(input string name, input logic [31:0] irv, input int waits);
      applyStimulus({name, ".T0"}, 1'b1, irv, 1'b0, 1'b1, ST_T0, O_T0);
      for (int i = 0; i < waits; i++) begin
         applyStimulus({name, ".T1wait"}, 1'b1, irv, 1'b0, 1'b0, ST_T1, O_T1);
      end
      applyStimulus({name, ".T1"}, 1'b1, irv, 1'b0, 1'b1, ST_T1, O_T1);
      applyStimulus({name, ".T2"}, 1'b1, irv, 1'b0, 1'b1, ST_T2, O_T2);
   endtask

   // Directed instruction sequence
   initial begin
      clear    = 1'b1;
      ir       = 32'h0;
      con      = 1'b0;
      memReady = 1'b1;
      #2;
      applyStimulus("reset.hold0", 1'b0, 32'h0, 1'b0, 1'b1, ST_IDLE, O_IDLE);
      applyStimulus("reset.hold1", 1'b0, 32'h0, 1'b0, 1'b1, ST_IDLE, O_IDLE);
      applyStimulus("reset.release", 1'b1, IR_JR, 1'b0, 1'b1, ST_IDLE, O_IDLE);

      fetchInstr("jr", IR_JR, 0);
      applyStimulus("jr.T3", 1'b1, IR_JR, 1'b0, 1'b1, ST_T3, O_JR3);

      fetchInstr("brTaken", IR_BR, 0);
      applyStimulus("brTaken.T3", 1'b1, IR_BR, 1'b1, 1'b1, ST_T3, O_BR3);
      applyStimulus("brTaken.T4", 1'b1, IR_BR, 1'b1, 1'b1, ST_T4, O_BR4);
      applyStimulus("brTaken.T5", 1'b1, IR_BR, 1'b1, 1'b1, ST_T5, O_BR5);
      applyStimulus("brTaken.T6", 1'b1, IR_BR, 1'b1, 1'b1, ST_T6, O_BR6T);

      fetchInstr("brNot", IR_BR, 0);
      applyStimulus("brNot.T3", 1'b1, IR_BR, 1'b0, 1'b1, ST_T3, O_BR3);
      applyStimulus("brNot.T4", 1'b1, IR_BR, 1'b0, 1'b1, ST_T4, O_BR4);
      applyStimulus("brNot.T5", 1'b1, IR_BR, 1'b0, 1'b1, ST_T5, O_BR5);
      applyStimulus("brNot.T6", 1'b1, IR_BR, 1'b0, 1'b1, ST_T6, O_BR6N);

      fetchInstr("jrWait", IR_JR, 3);
      applyStimulus("jrWait.T3", 1'b1, IR_JR, 1'b0, 1'b1, ST_T3, O_JR3);

      fetchInstr("jal", IR_JAL, 0);
      applyStimulus("jal.T3", 1'b1, IR_JAL, 1'b0, 1'b1, ST_T3, O_JAL3);
      applyStimulus("jal.T4", 1'b1, IR_JAL, 1'b0, 1'b1, ST_T4, O_JR3);

      fetchInstr("nop", IR_NOP, 0);
      applyStimulus("nop.T3", 1'b1, IR_NOP, 1'b0, 1'b1, ST_T3, O_NONE);

      fetchInstr("unsup", IR_UNS, 0);
      applyStimulus("unsup.T3", 1'b1, IR_UNS, 1'b0, 1'b1, ST_T3, O_UNS);

      fetchInstr("brReset", IR_BR, 0);
      applyStimulus("brReset.T3", 1'b1, IR_BR, 1'b1, 1'b1, ST_T3, O_BR3);
      applyStimulus("brReset.T4", 1'b1, IR_BR, 1'b1, 1'b1, ST_T4, O_BR4);
      applyStimulus("brReset.midT5", 1'b0, IR_BR, 1'b1, 1'b1, ST_IDLE, O_IDLE);
      applyStimulus("brReset.release", 1'b1, IR_JR, 1'b0, 1'b1, ST_IDLE, O_IDLE);

      fetchInstr("halt", IR_HALT, 0);
      applyStimulus("halt.T3", 1'b1, IR_HALT, 1'b0, 1'b1, ST_T3, O_NONE);
      for (int i = 0; i < 10; i++) begin
         applyStimulus("halt.stay", 1'b1, IR_HALT, 1'b0, 1'b1, ST_HALT, O_HALT);
      end
      applyStimulus("halt.clear", 1'b0, IR_HALT, 1'b0, 1'b1, ST_IDLE, O_IDLE);
      applyStimulus("halt.release", 1'b1, IR_JR, 1'b0, 1'b1, ST_IDLE, O_IDLE);
      applyStimulus("halt.restartT0", 1'b1, IR_JR, 1'b0, 1'b1, ST_T0, O_T0);

      for (int i = 0; i < 5 && expQ.size() != 0; i++) begin
         @(posedge clock);
         #1;
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
